// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller that wraps a 2-port RAM as a synchronous FWFT FIFO.
// Occupancy is held as an explicit count so full and empty never need an extra pointer bit.
module fifo_ctrl #(
  parameter int unsigned addr_width = 3,
  parameter int unsigned af_level   = 6,
  parameter int unsigned ae_level   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  we,
  output logic [addr_width-1:0] w_addr,
  output logic [addr_width-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** addr_width;

  localparam logic [addr_width:0]   CntDepth = (addr_width + 1)'(Depth);
  localparam logic [addr_width:0]   CntOne   = (addr_width + 1)'(1);
  localparam logic [addr_width:0]   AfLevel  = (addr_width + 1)'(af_level);
  localparam logic [addr_width:0]   AeLevel  = (addr_width + 1)'(ae_level);
  localparam logic [addr_width-1:0] PtrOne   = addr_width'(1);

  if (af_level == 0 || af_level > Depth || ae_level >= Depth) begin : g_param_check
    $error("fifo_ctrl: af_level must be in 1..depth and ae_level in 0..depth-1");
  end

  logic [addr_width-1:0] r_wptr;
  logic [addr_width-1:0] r_rptr;
  logic [addr_width:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full    = (r_count == CntDepth);
  assign w_empty   = (r_count == '0);
  // A pop at full frees the slot this push reuses; an empty FIFO never reads through.
  assign w_push_ok = wr & (~w_full | rd);
  assign w_pop_ok  = rd & ~w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PtrOne;
      if (w_pop_ok)  r_rptr <= r_rptr + PtrOne;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
      if (wr & ~w_push_ok) r_overflow  <= 1'b1;
      if (rd & ~w_pop_ok)  r_underflow <= 1'b1;
    end
  end

  assign we           = w_push_ok;
  assign w_addr       = r_wptr;
  assign r_addr       = r_rptr;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AfLevel);
  assign almost_empty = (r_count <= AeLevel);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed push/pop vectors feed a status and data scoreboard
// that a negedge monitor drains, with a behavioural 8x8 RAM standing in for the real array.
module tb_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic       wr;
  logic       rd;
  logic       we;
  logic [2:0] w_addr;
  logic [2:0] r_addr;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  fifo_ctrl #(
    .addr_width(3),
    .af_level  (6),
    .ae_level  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .rd          (rd),
    .we          (we),
    .w_addr      (w_addr),
    .r_addr      (r_addr),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, asynchronous read.
  logic [7:0] mem [8];
  logic [7:0] wdata;
  always @(posedge clk) if (we) mem[w_addr] <= wdata;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [2:0] ra;
    logic [3:0] cnt;
    logic       ovf;
    logic       udf;
  } st_t;

  st_t        st_q[$];
  logic [7:0] data_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected state tracked from hand-supplied accept decisions.
  logic [2:0] m_wp;
  logic [2:0] m_rp;
  logic [3:0] m_cnt;
  logic       m_ovf;
  logic       m_udf;

  st_t        e;
  logic [2:0] diff;
  logic [7:0] exp_d;

  always @(negedge clk) begin
    if (!reset) begin
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("we",           32'(we),           32'(e.we));
        chk("w_addr",       32'(w_addr),       32'(e.wa));
        chk("r_addr",       32'(r_addr),       32'(e.ra));
        chk("count",        32'(count),        32'(e.cnt));
        chk("full",         32'(full),         32'(e.cnt == 4'd8));
        chk("empty",        32'(empty),        32'(e.cnt == 4'd0));
        chk("almost_full",  32'(almost_full),  32'(e.cnt >= 4'd6));
        chk("almost_empty", 32'(almost_empty), 32'(e.cnt <= 4'd2));
        chk("overflow",     32'(overflow),     32'(e.ovf));
        chk("underflow",    32'(underflow),    32'(e.udf));
      end
      diff = w_addr - r_addr;
      if (count == 4'd8) chk("ptr_eq_at_full", 32'(w_addr), 32'(r_addr));
      else               chk("invariant", 32'(count), 32'({1'b0, diff}));
      if (rd && !empty) begin
        if (data_q.size() == 0) begin
          chk("data_q_nonempty", 32'(0), 32'(1));
        end else begin
          exp_d = data_q.pop_front();
          chk("rdata", 32'(mem[r_addr]), 32'(exp_d));
        end
      end
    end
  end

  task automatic apply_reset();
    wr    = 1'b0;
    rd    = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_wp  = '0;
    m_rp  = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    st_q.delete();
    data_q.delete();
  endtask

  // One clock of stimulus; e_we/e_pop are the hand-determined accept outcomes.
  task automatic step(input logic i_wr, input logic i_rd, input logic e_we, input logic e_pop,
                      input logic [7:0] d);
    wr    = i_wr;
    rd    = i_rd;
    wdata = d;
    st_q.push_back('{we: e_we, wa: m_wp, ra: m_rp, cnt: m_cnt, ovf: m_ovf, udf: m_udf});
    if (e_we) data_q.push_back(d);
    @(posedge clk);
    #1;
    if (e_we)  m_wp = m_wp + 3'd1;
    if (e_pop) m_rp = m_rp + 3'd1;
    if (e_we && !e_pop) m_cnt = m_cnt + 4'd1;
    else if (e_pop && !e_we) m_cnt = m_cnt - 4'd1;
    if (i_wr && !e_we)  m_ovf = 1'b1;
    if (i_rd && !e_pop) m_udf = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wdata = 8'h00;
    apply_reset();

    // Idle after reset, then async reset in the middle of a fill.
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_count",  32'(count),        32'(0));
    chk("rst_empty",  32'(empty),        32'(1));
    chk("rst_full",   32'(full),         32'(0));
    chk("rst_ae",     32'(almost_empty), 32'(1));
    chk("rst_af",     32'(almost_full),  32'(0));
    chk("rst_waddr",  32'(w_addr),       32'(0));
    chk("rst_raddr",  32'(r_addr),       32'(0));
    chk("rst_we",     32'(we),           32'(0));
    apply_reset();

    // Fill to full, then one rejected push.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(i * 17));
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // Drain in order, then one rejected pop.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Simultaneous push/pop at full reuses the freed slot.
    apply_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(i * 17));
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Simultaneous push/pop at empty: write only, pop rejected.
    apply_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // 20 pushes holding count at 3: pointers wrap twice.
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 3; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 8'(8'hA0 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Steady simultaneous traffic at count 4.
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 4; i < 14; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 8'(8'h40 + i));
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    @(posedge clk);
    #1;
    chk("status_q_drained", 32'(st_q.size()), 32'(0));
    chk("data_q_left",      32'(data_q.size()), 32'(4));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
